// File: rtl/branch_unit_pkg.sv
// Shared branch types: the 3-bit BrFunc condition encoding used by the branch unit and its comparator.
package branch_unit_pkg;

  typedef enum logic [2:0] {
    BR_EQ   = 3'd0,
    BR_NEQ  = 3'd1,
    BR_LT   = 3'd2,
    BR_LTU  = 3'd3,
    BR_GE   = 3'd4,
    BR_GEU  = 3'd5,
    BR_DBR  = 3'd6,
    BR_NONE = 3'd7
  } br_func_e;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; signed/unsigned compares at XLEN bits.
module branch_cmp
  import branch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rval1,
  input  logic [XLEN-1:0] rval2,
  input  br_func_e        brFunc,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (brFunc)
      BR_EQ:   taken = (rval1 == rval2);
      BR_NEQ:  taken = (rval1 != rval2);
      BR_LT:   taken = ($signed(rval1) < $signed(rval2));
      BR_LTU:  taken = (rval1 < rval2);
      BR_GE:   taken = ($signed(rval1) >= $signed(rval2));
      BR_GEU:  taken = (rval1 >= rval2);
      BR_DBR:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolve unit with one registered output stage (1-cycle latency, valid/ready, flush, mispredict counter).
// Optional JALR resolution when BRU_JALR_EN is defined; otherwise jalr_in is ignored.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             issue_valid_in,
  output logic             issue_ready_out,
  input  logic [XLEN-1:0]  rval1_in,
  input  logic [XLEN-1:0]  rval2_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic [2:0]       brFunc_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             pred_taken_in,
  input  logic [XLEN-1:0]  pred_target_in,
  input  logic             jalr_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [TAG_W-1:0] res_tag_out,
  output logic             res_taken_out,
  output logic [XLEN-1:0]  res_next_pc_out,
  output logic [XLEN-1:0]  res_link_out,
  output logic             res_mispredict_out,
  input  logic             flush_in,
  output logic [CNT_W-1:0] mispredict_count_out
);

  logic            cmp_taken;
  logic            taken;
  logic            mispredict;
  logic            accept;
  logic            drain;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rval1  (rval1_in),
    .rval2  (rval2_in),
    .brFunc (br_func_e'(brFunc_in)),
    .taken  (cmp_taken)
  );

  assign seq_pc = pc_in + XLEN'(4);

`ifdef BRU_JALR_EN
  always_comb begin
    if (jalr_in) begin
      taken  = 1'b1;
      target = (rval1_in + imm_in) & {{(XLEN-1){1'b1}}, 1'b0};
    end else begin
      taken  = cmp_taken;
      target = pc_in + imm_in;
    end
  end
`else
  logic jalr_unused;
  assign jalr_unused = jalr_in;
  assign taken       = cmp_taken;
  assign target      = pc_in + imm_in;
`endif

  assign next_pc    = taken ? target : seq_pc;
  assign mispredict = (taken != pred_taken_in) || (taken && (target != pred_target_in));

  assign issue_ready_out = !res_valid_out || res_ready_in;
  // A flush discards the presented issue even when the stage could take it.
  assign accept = issue_valid_in && issue_ready_out && !flush_in;
  assign drain  = res_valid_out && res_ready_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      res_valid_out        <= 1'b0;
      res_tag_out          <= '0;
      res_taken_out        <= 1'b0;
      res_next_pc_out      <= '0;
      res_link_out         <= '0;
      res_mispredict_out   <= 1'b0;
      mispredict_count_out <= '0;
    end else begin
      if (accept) begin
        res_valid_out      <= 1'b1;
        res_tag_out        <= tag_in;
        res_taken_out      <= taken;
        res_next_pc_out    <= next_pc;
        res_link_out       <= seq_pc;
        res_mispredict_out <= mispredict;
      end else if (flush_in || drain) begin
        res_valid_out <= 1'b0;
      end
      if (drain && res_mispredict_out && (mispredict_count_out != {CNT_W{1'b1}})) begin
        mispredict_count_out <= mispredict_count_out + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: vector table, directed handshake/flush/reset sequences, random vs. reference model.
module tb_branch_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int CNT_W = 5;
  localparam logic [31:0] CNT_MAX = 32'd31;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic             issue_ready;
  logic [XLEN-1:0]  rval1, rval2, pc, imm, pred_target;
  logic [2:0]       br_func;
  logic [TAG_W-1:0] tag;
  logic             pred_taken, jalr;
  logic             res_valid, res_ready, res_taken, res_misp, flush;
  logic [TAG_W-1:0] res_tag;
  logic [XLEN-1:0]  res_next_pc, res_link;
  logic [CNT_W-1:0] misp_count;

  branch_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_in               (clk),
    .rst_in               (rst),
    .issue_valid_in       (issue_valid),
    .issue_ready_out      (issue_ready),
    .rval1_in             (rval1),
    .rval2_in             (rval2),
    .pc_in                (pc),
    .imm_in               (imm),
    .brFunc_in            (br_func),
    .tag_in               (tag),
    .pred_taken_in        (pred_taken),
    .pred_target_in       (pred_target),
    .jalr_in              (jalr),
    .res_valid_out        (res_valid),
    .res_ready_in         (res_ready),
    .res_tag_out          (res_tag),
    .res_taken_out        (res_taken),
    .res_next_pc_out      (res_next_pc),
    .res_link_out         (res_link),
    .res_mispredict_out   (res_misp),
    .flush_in             (flush),
    .mispredict_count_out (misp_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        misp;
  } res_t;

  typedef struct {
    logic [31:0] r1, r2, pc, imm;
    logic [2:0]  f;
    logic        pt;
    logic [31:0] ptg;
    logic        j;
    res_t        exp;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] p,
                           input logic [31:0] im, input logic [2:0] f, input logic pt,
                           input logic [31:0] ptg, input logic j, input logic [3:0] tg);
    issue_valid = 1'b1;
    rval1 = r1; rval2 = r2; pc = p; imm = im; br_func = f;
    pred_taken = pt; pred_target = ptg; jalr = j; tag = tg;
  endtask

  task automatic do_reset();
    issue_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] p,
                              input logic [31:0] im, input logic [2:0] f, input logic pt,
                              input logic [31:0] ptg, input logic j, input logic tk,
                              input logic [31:0] npc, input logic [31:0] lnk, input logic mp);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.pc = p; v.imm = im; v.f = f; v.pt = pt; v.ptg = ptg; v.j = j;
    v.exp = '{taken: tk, next_pc: npc, link: lnk, misp: mp};
    return v;
  endfunction

  // Reference semantics straight from the branch rules; jalr comes from the driven bench signal.
  function automatic res_t ref_model(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] p,
                                     input logic [31:0] im, input logic [2:0] f, input logic pt,
                                     input logic [31:0] ptg);
    res_t r;
    logic [31:0] tgt;
    tgt = p + im;
    case (f)
      3'd0:    r.taken = (r1 == r2);
      3'd1:    r.taken = (r1 != r2);
      3'd2:    r.taken = ($signed(r1) < $signed(r2));
      3'd3:    r.taken = (r1 < r2);
      3'd4:    r.taken = ($signed(r1) >= $signed(r2));
      3'd5:    r.taken = (r1 >= r2);
      3'd6:    r.taken = 1'b1;
      default: r.taken = 1'b0;
    endcase
`ifdef BRU_JALR_EN
    if (jalr) begin
      r.taken = 1'b1;
      tgt = (r1 + im) & 32'hFFFF_FFFE;
    end
`endif
    r.link    = p + 32'd4;
    r.next_pc = r.taken ? tgt : r.link;
    r.misp    = (r.taken != pt) || (r.taken && (tgt != ptg));
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[10];

  initial begin
    logic [31:0] exp_cnt;
    logic        mvalid;
    res_t        mres;
    logic [3:0]  mtag;
    logic        rdy, drn;

    rst = 1'b1; issue_valid = 1'b0; res_ready = 1'b0; flush = 1'b0;
    rval1 = '0; rval2 = '0; pc = '0; imm = '0; br_func = '0; tag = '0;
    pred_taken = 1'b0; pred_target = '0; jalr = 1'b0;

    #1;
    chk("reset_valid",   32'(res_valid),   32'd0);
    chk("reset_count",   32'(misp_count),  32'd0);
    chk("reset_next_pc", res_next_pc,      32'd0);
    chk("reset_link",    res_link,         32'd0);
    chk("reset_tag",     32'(res_tag),     32'd0);
    chk("reset_misp",    32'(res_misp),    32'd0);
    tick();
    rst = 1'b0;

    vecs[0] = mk(32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 3'd2, 1'b1, 32'h120, 1'b0, 1'b1, 32'h120, 32'h104, 1'b0);
    vecs[1] = mk(32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 3'd3, 1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 32'h104, 1'b0);
    vecs[2] = mk(32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 3'd5, 1'b0, 32'h0,   1'b0, 1'b1, 32'h120, 32'h104, 1'b1);
    vecs[3] = mk(32'd5, 32'd5, 32'h100, 32'h20, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h120, 32'h104, 1'b1);
    vecs[4] = mk(32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 3'd1, 1'b1, 32'h4, 1'b0, 1'b1, 32'h4, 32'h0, 1'b0);
    vecs[5] = mk(32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 3'd4, 1'b1, 32'h120, 1'b0, 1'b0, 32'h104, 32'h104, 1'b1);
    vecs[6] = mk(32'd0, 32'd0, 32'h100, 32'h20, 3'd6, 1'b1, 32'h999, 1'b0, 1'b1, 32'h120, 32'h104, 1'b1);
    vecs[7] = mk(32'd7, 32'd7, 32'h100, 32'h20, 3'd7, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104, 32'h104, 1'b0);
    vecs[8] = mk(32'd3, 32'd4, 32'h100, 32'h20, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104, 32'h104, 1'b0);
`ifdef BRU_JALR_EN
    vecs[9] = mk(32'h1001, 32'h1001, 32'h100, 32'h10, 3'd0, 1'b1, 32'h1010, 1'b1, 1'b1, 32'h1010, 32'h104, 1'b0);
`else
    vecs[9] = mk(32'h1001, 32'h1001, 32'h100, 32'h10, 3'd0, 1'b1, 32'h1010, 1'b1, 1'b1, 32'h110, 32'h104, 1'b1);
`endif

    exp_cnt = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_issue(vecs[i].r1, vecs[i].r2, vecs[i].pc, vecs[i].imm, vecs[i].f,
                vecs[i].pt, vecs[i].ptg, vecs[i].j, 4'(i));
      tick();
      chk($sformatf("vec%0d_valid", i),   32'(res_valid),  32'd1);
      chk($sformatf("vec%0d_tag", i),     32'(res_tag),    32'(i));
      chk($sformatf("vec%0d_taken", i),   32'(res_taken),  32'(vecs[i].exp.taken));
      chk($sformatf("vec%0d_next_pc", i), res_next_pc,     vecs[i].exp.next_pc);
      chk($sformatf("vec%0d_link", i),    res_link,        vecs[i].exp.link);
      chk($sformatf("vec%0d_misp", i),    32'(res_misp),   32'(vecs[i].exp.misp));
      chk($sformatf("vec%0d_count", i),   32'(misp_count), exp_cnt);
      exp_cnt = exp_cnt + 32'(vecs[i].exp.misp);
    end
    issue_valid = 1'b0;
    tick();
    chk("table_drain_valid", 32'(res_valid),  32'd0);
    chk("table_drain_count", 32'(misp_count), exp_cnt);

    // Single mispredicted Eq branch bumps the counter exactly once on its handshake.
    do_reset();
    res_ready = 1'b1;
    set_issue(32'd5, 32'd5, 32'h100, 32'h20, 3'd0, 1'b0, 32'h0, 1'b0, 4'd3);
    tick();
    chk("eq_next_pc",      res_next_pc,      32'h120);
    chk("eq_misp",         32'(res_misp),    32'd1);
    chk("eq_count_before", 32'(misp_count),  32'd0);
    issue_valid = 1'b0;
    tick();
    chk("eq_count_after",  32'(misp_count),  32'd1);
    chk("eq_valid_after",  32'(res_valid),   32'd0);

    // Backpressure: result holds for 3 stalled cycles, then one result per cycle.
    set_issue(32'd1, 32'd1, 32'h200, 32'h40, 3'd0, 1'b1, 32'h240, 1'b0, 4'd1);
    tick();
    chk("stall_first_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b0;
    set_issue(32'd1, 32'd2, 32'h300, 32'h8, 3'd1, 1'b1, 32'h308, 1'b0, 4'd2);
    #1;
    chk("stall_ready_low", 32'(issue_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid",   32'(res_valid),   32'd1);
      chk("stall_tag",     32'(res_tag),     32'd1);
      chk("stall_next_pc", res_next_pc,      32'h240);
      chk("stall_ready",   32'(issue_ready), 32'd0);
    end
    res_ready = 1'b1;
    #1;
    chk("unstall_ready", 32'(issue_ready), 32'd1);
    tick();
    chk("b2b_tag_b",     32'(res_tag),   32'd2);
    chk("b2b_next_pc_b", res_next_pc,    32'h308);
    for (int k = 3; k < 7; k++) begin
      set_issue(32'd0, 32'd0, 32'(k * 16), 32'd4, 3'd6, 1'b1, 32'(k * 16 + 4), 1'b0, 4'(k));
      tick();
      chk("b2b_valid",   32'(res_valid),   32'd1);
      chk("b2b_tag",     32'(res_tag),     32'(k));
      chk("b2b_next_pc", res_next_pc,      32'(k * 16 + 4));
    end

    // Flush kills a pending mispredicted result and the issue presented alongside it.
    do_reset();
    set_issue(32'd0, 32'd0, 32'h40, 32'd4, 3'd6, 1'b0, 32'h0, 1'b0, 4'd7);
    tick();
    chk("flush_pending_valid", 32'(res_valid), 32'd1);
    set_issue(32'd0, 32'd0, 32'h80, 32'd4, 3'd6, 1'b0, 32'h0, 1'b0, 4'd8);
    flush = 1'b1;
    tick();
    chk("flush_valid_cleared", 32'(res_valid), 32'd0);
    flush = 1'b0; issue_valid = 1'b0; res_ready = 1'b1;
    tick();
    chk("flush_no_result",   32'(res_valid),  32'd0);
    chk("flush_count_clean", 32'(misp_count), 32'd0);
    set_issue(32'd0, 32'd0, 32'h80, 32'd4, 3'd6, 1'b0, 32'h0, 1'b0, 4'd9);
    flush = 1'b1;
    #1;
    chk("flush_ready_high", 32'(issue_ready), 32'd1);
    tick();
    chk("flush_discard_issue", 32'(res_valid), 32'd0);
    flush = 1'b0;

    // Counter saturates at its maximum.
    set_issue(32'd0, 32'd0, 32'h40, 32'd4, 3'd6, 1'b0, 32'h0, 1'b0, 4'd1);
    repeat (40) tick();
    issue_valid = 1'b0;
    tick();
    chk("count_saturated", 32'(misp_count), CNT_MAX);

    // Reset mid-operation drops the pending result immediately.
    res_ready = 1'b0;
    set_issue(32'd0, 32'd0, 32'h40, 32'd4, 3'd6, 1'b0, 32'h0, 1'b0, 4'd5);
    tick();
    chk("midrst_pending", 32'(res_valid), 32'd1);
    issue_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid",   32'(res_valid),  32'd0);
    chk("midrst_count",   32'(misp_count), 32'd0);
    chk("midrst_next_pc", res_next_pc,     32'd0);
    chk("midrst_link",    res_link,        32'd0);
    chk("midrst_tag",     32'(res_tag),    32'd0);
    #1 rst = 1'b0;
    tick();
    chk("postrst_valid", 32'(res_valid), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    mvalid = 1'b0; mres = '0; mtag = '0; exp_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", 32'(res_valid),  32'(mvalid));
      chk("rnd_count", 32'(misp_count), exp_cnt);
      if (mvalid) begin
        chk("rnd_tag",     32'(res_tag),   32'(mtag));
        chk("rnd_taken",   32'(res_taken), 32'(mres.taken));
        chk("rnd_next_pc", res_next_pc,    mres.next_pc);
        chk("rnd_link",    res_link,       mres.link);
        chk("rnd_misp",    32'(res_misp),  32'(mres.misp));
      end
      issue_valid = ($urandom_range(0, 9) < 7);
      res_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 19) == 0);
      rval1       = pick();
      rval2       = ($urandom_range(0, 2) == 0) ? rval1 : pick();
      pc          = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      imm         = $urandom;
      br_func     = 3'($urandom_range(0, 7));
      pred_taken  = 1'($urandom_range(0, 1));
      pred_target = ($urandom_range(0, 1) == 0) ? (pc + imm) : $urandom;
      jalr        = 1'($urandom_range(0, 1));
      tag         = 4'($urandom_range(0, 15));
      #1;
      rdy = !mvalid || res_ready;
      drn = mvalid && res_ready;
      chk("rnd_issue_ready", 32'(issue_ready), 32'(rdy));
      if (drn && mres.misp && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1;
      if (issue_valid && rdy && !flush) begin
        mvalid = 1'b1;
        mres   = ref_model(rval1, rval2, pc, imm, br_func, pred_taken, pred_target);
        mtag   = tag;
      end else if (flush || drn) begin
        mvalid = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
